udma_hyper_cfg_master: RTL and testbench
========================================

# udma_hyper_cfg_master

Configuration-bus initiator that programs the HyperBus common register block after reset or on software request. It latches a set of target timing values, writes them to the common registers in fixed address order, optionally reads each one back and compares it, and finally reads the transaction-ID allocation register. It sits between the boot/control logic and the cfg_* port of the common register interface and drives the same word-addressed bus that register block responds to.

## Interface
- NB_CH, 1: channel count of the target; ID_W = (NB_CH>1) ? $clog2(NB_CH) : 1
- DELAY_BIT_WIDTH, 3: width of the RWDS delay-line field
- TIMEOUT, 255: maximum number of stall cycles per transfer; 0 disables the timeout
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; accepted only in IDLE
- verify_i  in  1  enable readback/compare; sampled with start_i
- page_bound_i  in  3  value for address 0x00
- t_latency_access_i  in  5  value for address 0x01
- en_latency_add_i  in  1  value for address 0x02
- t_cs_max_i  in  32  value for address 0x03
- t_rw_recovery_i  in  32  value for address 0x04
- t_rwds_delay_i  in  DELAY_BIT_WIDTH  value for address 0x05
- t_vari_latency_i  in  4  value for address 0x06
- n_hyperdevice_i  in  3  value for address 0x07
- mem_sel_i  in  2  value for address 0x08
- cfg_data_o  out  32  write data
- cfg_addr_o  out  5  register address
- cfg_valid_o  out  1  request valid
- cfg_reg_rwn_o  out  1  1 = read, 0 = write
- cfg_data_i  in  32  read data; valid in the same cycle as cfg_ready_i
- cfg_ready_i  in  1  the transfer completes in any cycle where cfg_valid_o & cfg_ready_i
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag; cleared on the next accepted start
- timeout_o  out  1  sticky flag, set when the error was a timeout
- err_addr_o  out  5  address of the first error
- alloc_id_o  out  ID_W  ID read from address 0x09
- alloc_valid_o  out  1  alloc_id_o is valid; cleared on the next accepted start

## Operation
- States: IDLE, WR, RD, ALLOC, DONE. A 4-bit index idx runs from 0 to 8 and is the register address.
- IDLE: start_i=1 does all of the following:
  - latches every value input and verify_i into shadow registers (later input changes have no effect);
  - clears err_o, timeout_o, err_addr_o, alloc_valid_o;
  - sets idx=0 and goes to WR.
- Start while not in IDLE is ignored.
- WR:
  - Drives cfg_valid_o=1, cfg_reg_rwn_o=0, cfg_addr_o=idx, cfg_data_o = shadow value zero-extended to 32 bits.
  - On handshake: goes to RD if verify is set; otherwise increments idx, or goes to ALLOC when idx==8.
- RD:
  - Drives cfg_valid_o=1, cfg_reg_rwn_o=1, same address, cfg_data_o=0.
  - On handshake: compares the full 32-bit cfg_data_i with the zero-extended expected value.
  - On mismatch: sets err_o=1. err_addr_o captures idx only if err_o was 0 (first error wins).
  - The sequence continues after a mismatch. Then increments idx, or goes to ALLOC when idx==8.
- ALLOC:
  - Drives a read of address 0x09.
  - On handshake: alloc_id_o <= cfg_data_i[ID_W-1:0], alloc_valid_o <= 1, then goes to DONE.
- DONE: done_o=1 for exactly one cycle, then returns to IDLE.
- Timeout:
  - A stall counter clears on every handshake and when cfg_valid_o=0, and increments on each cycle with valid & ~ready.
  - When it reaches TIMEOUT (TIMEOUT≠0), the next state is DONE and cfg_valid_o drops next cycle.
  - At the same time: err_o=1, timeout_o=1, and err_addr_o = current address (the first-error rule applies).
  - No alloc result is produced.
- cfg_* outputs decode from registered state only; there is no combinational path from any input to them.
- Outside WR/RD/ALLOC: cfg_valid_o=0, cfg_addr_o=0, cfg_data_o=0, cfg_reg_rwn_o=0.
- busy_o = state ∈ {WR, RD, ALLOC}.
- Reset mid-sequence: immediate return to IDLE; all outputs take their reset values. There is no partial-state retention.

## Timing
- Reset values: every output is 0, state is IDLE.
- start_i is high in cycle 0 → cfg_valid_o is high in cycle 1 (addr 0x00, write).
- With cfg_ready_i constantly 1:
  - verify=0: writes in cycles 1–9, ALLOC in cycle 10, done_o in cycle 11, IDLE in cycle 12.
  - verify=1: 18 transfers in cycles 1–18, ALLOC in cycle 19, done_o in cycle 20.
- Each stall cycle adds exactly one cycle. The request holds addr, data and rwn stable until the handshake.
- Timeout: valid is raised in cycle n and ready is never asserted → DONE in cycle n+TIMEOUT, done_o high that cycle.

## Test plan
- Reset, then start with verify=0 and ready=1: write sequence addr 0..8 with data {3'h5→0x5, …, t_cs_max 665→0x299}, then read 0x09 returning 0 → alloc_id_o=0, alloc_valid_o=1, done_o in cycle 11, err_o=0.
- verify=1 with a responder model that echoes the written values: 19 transfers, alternating write/read per address, done_o in cycle 20, err_o=0.
- verify=1 with the responder returning 0x7 instead of 0x2 at addr 0x05 and a mismatch at 0x07: err_o=1, err_addr_o=0x05, sequence completes, alloc_valid_o=1.
- TIMEOUT=4, ready held low at addr 0x03: valid held for 4 cycles, then DONE; err_o=1, timeout_o=1, err_addr_o=0x03, alloc_valid_o=0.
- NB_CH=4, responder returns 0x2 at 0x09: alloc_id_o=2'b10. Random ready stalls give identical results with address/data held stable. start_i pulsed mid-sequence is ignored.
- Deassert rst_ni in the middle of a write: all outputs are 0 immediately. A fresh start_i afterwards restarts at addr 0 with err_o cleared.

Source files
------------

// File: rtl/udma_hyper_cfg_master.sv
// Configuration-bus initiator: writes latched timing values to the HyperBus common
// registers 0x00..0x08, optionally reads each back, then reads the alloc ID at 0x09.
module udma_hyper_cfg_master #(
    parameter int NB_CH           = 1,
    parameter int DELAY_BIT_WIDTH = 3,
    parameter int TIMEOUT         = 255,
    localparam int ID_W           = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       verify_i,
    input  logic [2:0]                 page_bound_i,
    input  logic [4:0]                 t_latency_access_i,
    input  logic                       en_latency_add_i,
    input  logic [31:0]                t_cs_max_i,
    input  logic [31:0]                t_rw_recovery_i,
    input  logic [DELAY_BIT_WIDTH-1:0] t_rwds_delay_i,
    input  logic [3:0]                 t_vari_latency_i,
    input  logic [2:0]                 n_hyperdevice_i,
    input  logic [1:0]                 mem_sel_i,
    output logic [31:0]                cfg_data_o,
    output logic [4:0]                 cfg_addr_o,
    output logic                       cfg_valid_o,
    output logic                       cfg_reg_rwn_o,
    input  logic [31:0]                cfg_data_i,
    input  logic                       cfg_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       timeout_o,
    output logic [4:0]                 err_addr_o,
    output logic [ID_W-1:0]            alloc_id_o,
    output logic                       alloc_valid_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR    = 3'd1;
    localparam logic [2:0] RD    = 3'd2;
    localparam logic [2:0] ALLOC = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CW = $clog2(TIMEOUT + 2);

    logic [2:0]                 r_state;
    logic [3:0]                 r_idx;
    logic                       r_verify;
    logic [2:0]                 r_page_bound;
    logic [4:0]                 r_t_latency_access;
    logic                       r_en_latency_add;
    logic [31:0]                r_t_cs_max;
    logic [31:0]                r_t_rw_recovery;
    logic [DELAY_BIT_WIDTH-1:0] r_t_rwds_delay;
    logic [3:0]                 r_t_vari_latency;
    logic [2:0]                 r_n_hyperdevice;
    logic [1:0]                 r_mem_sel;
    logic [CW-1:0]              r_stall;
    logic                       r_err;
    logic                       r_timeout;
    logic [4:0]                 r_err_addr;
    logic [ID_W-1:0]            r_alloc_id;
    logic                       r_alloc_valid;

    logic [31:0] w_expect;
    logic [4:0]  w_addr;
    logic        w_active;
    logic        w_hs;
    logic        w_tmo;
    logic        w_last;

    always_comb begin
        w_expect = '0;
        case (r_idx)
            4'd0:    w_expect = 32'(r_page_bound);
            4'd1:    w_expect = 32'(r_t_latency_access);
            4'd2:    w_expect = 32'(r_en_latency_add);
            4'd3:    w_expect = r_t_cs_max;
            4'd4:    w_expect = r_t_rw_recovery;
            4'd5:    w_expect = 32'(r_t_rwds_delay);
            4'd6:    w_expect = 32'(r_t_vari_latency);
            4'd7:    w_expect = 32'(r_n_hyperdevice);
            4'd8:    w_expect = 32'(r_mem_sel);
            default: w_expect = '0;
        endcase
    end

    always_comb begin
        w_addr = '0;
        if (r_state == WR || r_state == RD) w_addr = {1'b0, r_idx};
        else if (r_state == ALLOC)          w_addr = 5'd9;
    end

    assign w_active = (r_state == WR) || (r_state == RD) || (r_state == ALLOC);
    assign w_hs     = w_active && cfg_ready_i;
    assign w_last   = (r_idx == 4'd8);
    // Stall budget is exhausted on the cycle that would bring the counter to TIMEOUT.
    assign w_tmo    = (TIMEOUT != 0) && w_active && !cfg_ready_i &&
                      (r_stall == CW'(TIMEOUT - 1));

    assign cfg_valid_o   = w_active;
    assign cfg_reg_rwn_o = (r_state == RD) || (r_state == ALLOC);
    assign cfg_addr_o    = w_addr;
    assign cfg_data_o    = (r_state == WR) ? w_expect : '0;
    assign busy_o        = w_active;
    assign done_o        = (r_state == DONE);
    assign err_o         = r_err;
    assign timeout_o     = r_timeout;
    assign err_addr_o    = r_err_addr;
    assign alloc_id_o    = r_alloc_id;
    assign alloc_valid_o = r_alloc_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall <= '0;
        end else if (!w_active || w_hs) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state            <= IDLE;
            r_idx              <= '0;
            r_verify           <= 1'b0;
            r_page_bound       <= '0;
            r_t_latency_access <= '0;
            r_en_latency_add   <= 1'b0;
            r_t_cs_max         <= '0;
            r_t_rw_recovery    <= '0;
            r_t_rwds_delay     <= '0;
            r_t_vari_latency   <= '0;
            r_n_hyperdevice    <= '0;
            r_mem_sel          <= '0;
            r_err              <= 1'b0;
            r_timeout          <= 1'b0;
            r_err_addr         <= '0;
            r_alloc_id         <= '0;
            r_alloc_valid      <= 1'b0;
        end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            if (!r_err) r_err_addr <= w_addr;
            r_state   <= DONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_verify           <= verify_i;
                        r_page_bound       <= page_bound_i;
                        r_t_latency_access <= t_latency_access_i;
                        r_en_latency_add   <= en_latency_add_i;
                        r_t_cs_max         <= t_cs_max_i;
                        r_t_rw_recovery    <= t_rw_recovery_i;
                        r_t_rwds_delay     <= t_rwds_delay_i;
                        r_t_vari_latency   <= t_vari_latency_i;
                        r_n_hyperdevice    <= n_hyperdevice_i;
                        r_mem_sel          <= mem_sel_i;
                        r_err              <= 1'b0;
                        r_timeout          <= 1'b0;
                        r_err_addr         <= '0;
                        r_alloc_valid      <= 1'b0;
                        r_idx              <= '0;
                        r_state            <= WR;
                    end
                end
                WR: begin
                    if (w_hs) begin
                        if (r_verify)    r_state <= RD;
                        else if (w_last) r_state <= ALLOC;
                        else             r_idx   <= r_idx + 4'd1;
                    end
                end
                RD: begin
                    if (w_hs) begin
                        if (cfg_data_i != w_expect) begin
                            r_err <= 1'b1;
                            if (!r_err) r_err_addr <= w_addr;
                        end
                        if (w_last) begin
                            r_state <= ALLOC;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= WR;
                        end
                    end
                end
                ALLOC: begin
                    if (w_hs) begin
                        r_alloc_id    <= cfg_data_i[ID_W-1:0];
                        r_alloc_valid <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_hyper_cfg_master.sv
// Directed bench for udma_hyper_cfg_master: echo responder, corrupted readback,
// random ready stalls, timeout and mid-sequence reset.
module tb_udma_hyper_cfg_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, verify_i;
    logic [2:0]  page_bound_i;
    logic [4:0]  t_latency_access_i;
    logic        en_latency_add_i;
    logic [31:0] t_cs_max_i, t_rw_recovery_i;
    logic [2:0]  t_rwds_delay_i;
    logic [3:0]  t_vari_latency_i;
    logic [2:0]  n_hyperdevice_i;
    logic [1:0]  mem_sel_i;
    logic [31:0] cfg_data_o;
    logic [4:0]  cfg_addr_o;
    logic        cfg_valid_o, cfg_reg_rwn_o;
    logic [31:0] cfg_data_i;
    logic        cfg_ready_i;
    logic        busy_o, done_o, err_o, timeout_o;
    logic [4:0]  err_addr_o;
    logic [1:0]  alloc_id_o;
    logic        alloc_valid_o;

    udma_hyper_cfg_master #(.NB_CH(4), .DELAY_BIT_WIDTH(3), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .verify_i(verify_i),
        .page_bound_i(page_bound_i), .t_latency_access_i(t_latency_access_i),
        .en_latency_add_i(en_latency_add_i), .t_cs_max_i(t_cs_max_i),
        .t_rw_recovery_i(t_rw_recovery_i), .t_rwds_delay_i(t_rwds_delay_i),
        .t_vari_latency_i(t_vari_latency_i), .n_hyperdevice_i(n_hyperdevice_i),
        .mem_sel_i(mem_sel_i), .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o),
        .cfg_valid_o(cfg_valid_o), .cfg_reg_rwn_o(cfg_reg_rwn_o),
        .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o),
        .err_addr_o(err_addr_o), .alloc_id_o(alloc_id_o),
        .alloc_valid_o(alloc_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_val [9];
    logic [31:0] mem [16];
    logic [37:0] log_q [$];
    logic [31:0] alloc_val = '0;
    logic        corrupt = 1'b0, stall_en = 1'b0, rnd_mode = 1'b0, rnd_rdy = 1'b1;
    int          lowcnt = 0;
    logic        pend = 1'b0;
    logic [37:0] hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Responder: echoes the last written value, 0x09 returns alloc_val.
    always_comb begin
        cfg_data_i = mem[cfg_addr_o[3:0]];
        if (cfg_addr_o == 5'd9)             cfg_data_i = alloc_val;
        if (corrupt && cfg_addr_o == 5'd5)  cfg_data_i = 32'h7;
        if (corrupt && cfg_addr_o == 5'd7)  cfg_data_i = 32'h106;
    end

    always_comb begin
        if (rnd_mode) cfg_ready_i = rnd_rdy;
        else          cfg_ready_i = !(stall_en && cfg_addr_o == 5'd3);
    end

    always @(negedge clk_i) begin
        if (rnd_mode && lowcnt < 2 && $urandom_range(0, 1) == 0) begin
            rnd_rdy = 1'b0;
            lowcnt++;
        end else begin
            rnd_rdy = 1'b1;
            lowcnt  = 0;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && pend && cfg_valid_o)
            chk("stall_hold", {cfg_reg_rwn_o, cfg_addr_o, cfg_data_o}, hold);
        pend <= rst_ni && cfg_valid_o && !cfg_ready_i;
        hold <= {cfg_reg_rwn_o, cfg_addr_o, cfg_data_o};
        if (rst_ni && cfg_valid_o && cfg_ready_i) begin
            log_q.push_back({cfg_reg_rwn_o, cfg_addr_o, cfg_data_o});
            if (!cfg_reg_rwn_o) mem[cfg_addr_o[3:0]] <= cfg_data_o;
        end
    end

    task automatic set_vals();
        page_bound_i       = 3'h5;
        t_latency_access_i = 5'h1A;
        en_latency_add_i   = 1'b1;
        t_cs_max_i         = 32'd665;
        t_rw_recovery_i    = 32'hDEADBEEF;
        t_rwds_delay_i     = 3'h2;
        t_vari_latency_i   = 4'h9;
        n_hyperdevice_i    = 3'h6;
        mem_sel_i          = 2'h3;
    endtask

    task automatic do_start(input logic vfy);
        log_q.delete();
        @(negedge clk_i);
        verify_i = vfy;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        chk("first_req", {cfg_valid_o, cfg_reg_rwn_o, cfg_addr_o, cfg_data_o, busy_o},
            {1'b1, 1'b0, 5'd0, 32'h5, 1'b1});
    endtask

    task automatic wait_done(input int pulse_at, output int n, output int v3);
        n  = 1;
        v3 = 0;
        while (!done_o && n < 300) begin
            if (cfg_valid_o && cfg_addr_o == 5'd3) v3++;
            start_i = (n == pulse_at);
            @(negedge clk_i);
            n++;
        end
        start_i = 1'b0;
        chk("done_seen", {63'd0, done_o}, 64'd1);
    endtask

    task automatic check_log(input logic vfy);
        int          nexp;
        logic [37:0] e;
        nexp = vfy ? 19 : 10;
        chk("log_size", 64'(log_q.size()), 64'(nexp));
        for (int k = 0; k < nexp; k++) begin
            if (k == nexp - 1)  e = {1'b1, 5'd9, 32'h0};
            else if (!vfy)      e = {1'b0, 5'(k), exp_val[k]};
            else if (k % 2 == 0) e = {1'b0, 5'(k / 2), exp_val[k / 2]};
            else                e = {1'b1, 5'(k / 2), 32'h0};
            if (k < log_q.size()) chk($sformatf("log[%0d]", k), log_q[k], e);
        end
    endtask

    task automatic after_done();
        @(negedge clk_i);
        chk("idle_after_done", {62'd0, done_o, busy_o}, 64'd0);
    endtask

    int n, v3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_val = '{32'h5, 32'h1A, 32'h1, 32'h299, 32'hDEADBEEF, 32'h2, 32'h9, 32'h6, 32'h3};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_ni = 1'b0; start_i = 1'b0; verify_i = 1'b0;
        set_vals();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_state", {cfg_data_o, cfg_addr_o, cfg_valid_o, cfg_reg_rwn_o, busy_o,
            done_o, err_o, timeout_o, err_addr_o, alloc_id_o, alloc_valid_o}, 64'd0);

        // Write-only sequence; inputs scrambled after start must not matter.
        alloc_val = 32'h0;
        do_start(1'b0);
        page_bound_i = 3'h0; t_cs_max_i = 32'h0; t_rwds_delay_i = 3'h0; verify_i = 1'b1;
        wait_done(-1, n, v3);
        chk("t1_cycles", 64'(n), 64'd11);
        chk("t1_flags", {err_o, timeout_o, alloc_valid_o, alloc_id_o}, {3'b001, 2'd0});
        check_log(1'b0);
        after_done();
        set_vals();

        // Verify with echo responder.
        do_start(1'b1);
        wait_done(-1, n, v3);
        chk("t2_cycles", 64'(n), 64'd20);
        chk("t2_flags", {err_o, timeout_o, alloc_valid_o}, 3'b001);
        check_log(1'b1);
        after_done();

        // Corrupted readback at 0x05 and 0x07: first error address wins.
        corrupt = 1'b1;
        do_start(1'b1);
        wait_done(-1, n, v3);
        chk("t3_cycles", 64'(n), 64'd20);
        chk("t3_flags", {err_o, timeout_o, alloc_valid_o, err_addr_o}, {3'b101, 5'd5});
        check_log(1'b1);
        corrupt = 1'b0;
        after_done();

        // Random stalls, ID readback on NB_CH=4, ignored mid-sequence start.
        alloc_val = 32'hFFFF_FFF2;
        rnd_mode  = 1'b1;
        do_start(1'b1);
        wait_done(6, n, v3);
        rnd_mode  = 1'b0;
        chk("t4_min_cycles", 64'(n >= 20), 64'd1);
        chk("t4_flags", {err_o, timeout_o, alloc_valid_o, alloc_id_o}, {3'b001, 2'b10});
        check_log(1'b1);
        after_done();

        // Timeout: ready held low at 0x03.
        stall_en = 1'b1;
        do_start(1'b0);
        wait_done(-1, n, v3);
        chk("t5_cycles", 64'(n), 64'd8);
        chk("t5_valid_cycles", 64'(v3), 64'd4);
        chk("t5_flags", {err_o, timeout_o, alloc_valid_o, err_addr_o}, {3'b110, 5'd3});
        chk("t5_log_size", 64'(log_q.size()), 64'd3);
        stall_en = 1'b0;
        after_done();

        // Reset mid-sequence while an error is already flagged.
        corrupt = 1'b1;
        do_start(1'b1);
        n = 0;
        while (!err_o && n < 50) begin @(negedge clk_i); n++; end
        chk("t6_err_before_rst", {62'd0, err_o, busy_o}, 64'd3);
        rst_ni = 1'b0;
        #1;
        chk("t6_reset_outputs", {cfg_data_o, cfg_addr_o, cfg_valid_o, cfg_reg_rwn_o, busy_o,
            done_o, err_o, timeout_o, err_addr_o, alloc_id_o, alloc_valid_o}, 64'd0);
        corrupt = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Fresh start after reset.
        do_start(1'b0);
        chk("t7_err_cleared", {63'd0, err_o}, 64'd0);
        wait_done(-1, n, v3);
        chk("t7_cycles", 64'(n), 64'd11);
        check_log(1'b0);
        after_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
